// File: rtl/ps2_host_ctrl.sv
// PS/2 host controller for the keyboard port.
// Owns the open-drain PS2C/PS2D lines: receives device frames, sends host
// commands with the inhibit/request-to-send handshake, checks the line ACK
// and waits for the device's 0xFA/0xFE reply, resending on 0xFE.
//
// Command handshake: a command transfers on any cycle where cmd_valid and
// cmd_ready are both high; cmd_byte must be stable while cmd_valid is high,
// and cmd_valid may stay high while an incoming device frame is received.
module ps2_host_ctrl #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk_25MHz,
  input  logic       clr_n,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_INHIBIT, S_RTS, S_TX, S_LACK, S_RESP, S_RESP_RX
  } state_t;

  // Input conditioning
  logic [1:0] c_sync, d_sync;
  logic [7:0] c_shift, d_shift;
  logic       c_filt, d_filt;
  logic       fall;

  // FSM and datapath registers with their next values
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [9:0]      sh_q, sh_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            c_oe_d, d_oe_d;
  logic [7:0]      rx_byte_d;
  logic            rx_valid_d, rx_err_d, tx_done_d, tx_err_d;
  logic            tx_abort;

  // Complete frame as seen on the 11th fall: bit 0 start, 8:1 data, 9 parity, 10 stop
  logic [10:0] frame;
  logic [7:0]  frame_data;
  logic        frame_good;
  logic        timeout;

  assign frame      = {d_filt, sh_q};
  assign frame_data = frame[8:1];
  assign frame_good = !frame[0] && frame[10] && (^frame[9:1]);
  assign timeout    = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Falling edge of the filtered clock: the cycle the filter is about to drop
  assign fall      = c_filt && (c_shift == 8'h00);
  assign cmd_ready = (state_q == S_IDLE) && !fall && c_filt;
  assign busy      = (state_q != S_IDLE);

  // Synchronize and glitch-filter both pins; filtered level flips after 8 equal samples
  always_ff @(posedge clk_25MHz) begin
    if (!clr_n) begin
      c_sync  <= 2'b11;
      d_sync  <= 2'b11;
      c_shift <= 8'hFF;
      d_shift <= 8'hFF;
      c_filt  <= 1'b1;
      d_filt  <= 1'b1;
    end else begin
      c_sync  <= {c_sync[0], ps2c_in};
      d_sync  <= {d_sync[0], ps2d_in};
      c_shift <= {c_shift[6:0], c_sync[1]};
      d_shift <= {d_shift[6:0], d_sync[1]};
      if (c_shift == 8'h00)      c_filt <= 1'b0;
      else if (c_shift == 8'hFF) c_filt <= 1'b1;
      if (d_shift == 8'h00)      d_filt <= 1'b0;
      else if (d_shift == 8'hFF) d_filt <= 1'b1;
    end
  end

  // State and datapath registers; reset releases the lines immediately
  always_ff @(posedge clk_25MHz) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      cmd_q    <= '0;
      retry_q  <= '0;
      ps2c_oe  <= 1'b0;
      ps2d_oe  <= 1'b0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      cmd_q    <= cmd_d;
      retry_q  <= retry_d;
      ps2c_oe  <= c_oe_d;
      ps2d_oe  <= d_oe_d;
      rx_byte  <= rx_byte_d;
      rx_valid <= rx_valid_d;
      rx_err   <= rx_err_d;
      tx_done  <= tx_done_d;
      tx_err   <= tx_err_d;
    end
  end

  // Next-state, line drive and status pulses
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    bit_d      = bit_q;
    sh_d       = sh_q;
    cmd_d      = cmd_q;
    retry_d    = retry_q;
    c_oe_d     = ps2c_oe;
    d_oe_d     = ps2d_oe;
    rx_byte_d  = rx_byte;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    tx_abort   = 1'b0;

    case (state_q)
      S_IDLE: begin
        c_oe_d = 1'b0;
        d_oe_d = 1'b0;
        if (fall) begin
          // Device frame wins over any pending command
          sh_d    = {d_filt, sh_q[9:1]};
          bit_d   = 4'd1;
          state_d = S_RX;
        end else if (cmd_valid && cmd_ready) begin
          cmd_d   = cmd_byte;
          retry_d = '0;
          c_oe_d  = 1'b1;
          state_d = S_INHIBIT;
        end
      end

      S_RX, S_RESP_RX: begin
        if (fall) begin
          if (bit_q == 4'd10) begin
            state_d = S_IDLE;
            if (state_q == S_RX) begin
              if (frame_good) begin
                rx_valid_d = 1'b1;
                rx_byte_d  = frame_data;
              end else begin
                rx_err_d = 1'b1;
              end
            end else if (frame_good && frame_data == 8'hFA) begin
              tx_done_d = 1'b1;
            end else if (frame_good && frame_data == 8'hFE && retry_q < RW'(MAX_RETRY)) begin
              // Resend the same byte from a fresh inhibit phase
              retry_d = retry_q + RW'(1);
              c_oe_d  = 1'b1;
              state_d = S_INHIBIT;
            end else begin
              tx_err_d = 1'b1;
            end
          end else begin
            sh_d  = {d_filt, sh_q[9:1]};
            bit_d = bit_q + 4'd1;
          end
        end else if (timeout) begin
          if (state_q == S_RX) begin
            rx_err_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            tx_abort = 1'b1;
          end
        end
      end

      S_INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          // Release clock and present the start bit in the same cycle
          c_oe_d  = 1'b0;
          d_oe_d  = 1'b1;
          state_d = S_RTS;
        end
      end

      S_RTS: begin
        if (fall) begin
          d_oe_d  = ~cmd_q[0];
          bit_d   = 4'd1;
          state_d = S_TX;
        end else if (timeout) begin
          tx_abort = 1'b1;
        end
      end

      S_TX: begin
        if (fall) begin
          bit_d = bit_q + 4'd1;
          if (bit_q <= 4'd7) begin
            d_oe_d = ~cmd_q[bit_q[2:0]];
          end else if (bit_q == 4'd8) begin
            // Driving low when the odd-parity bit is 0
            d_oe_d = ^cmd_q;
          end else begin
            d_oe_d  = 1'b0;
            state_d = S_LACK;
          end
        end else if (timeout) begin
          tx_abort = 1'b1;
        end
      end

      S_LACK: begin
        if (fall) begin
          if (!d_filt) begin
            state_d = S_RESP;
          end else begin
            tx_err_d = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (timeout) begin
          tx_abort = 1'b1;
        end
      end

      S_RESP: begin
        if (fall) begin
          sh_d    = {d_filt, sh_q[9:1]};
          bit_d   = 4'd1;
          state_d = S_RESP_RX;
        end else if (timeout) begin
          tx_abort = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (tx_abort) begin
      c_oe_d   = 1'b0;
      d_oe_d   = 1'b0;
      tx_err_d = 1'b1;
      state_d  = S_IDLE;
    end

    // Our own clock pull during inhibit also creates a fall; it must not restart the inhibit count
    if (state_q == S_IDLE || state_d != state_q || (fall && state_q != S_INHIBIT)) begin
      cnt_d = '0;
    end
  end

endmodule
